// File: rtl/bus_arbiter_decoder.sv
// bus_arbiter_decoder: two-master shared-bus arbiter with address decode and registered read return
module bus_arbiter_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        M0_req,
   input  logic        M1_req,
   input  logic        M0_wr,
   input  logic        M1_wr,
   input  logic [7:0]  M0_address,
   input  logic [7:0]  M1_address,
   input  logic [31:0] M0_dout,
   input  logic [31:0] M1_dout,
   output logic        M0_grant,
   output logic        M1_grant,
   output logic        S_wr,
   output logic [7:0]  S_address,
   output logic [31:0] S_din,
   output logic        S0_sel,
   output logic        S1_sel,
   output logic        S2_sel,
   input  logic [31:0] S0_dout,
   input  logic [31:0] S1_dout,
   input  logic [31:0] S2_dout,
   output logic [31:0] M_din,
   output logic        bus_err
);
   typedef enum logic {M0_GNT, M1_GNT} state_t;
   typedef enum logic [1:0] {RD_S0, RD_S1, RD_S2, RD_NONE} rd_t;
   state_t state, state_next;
   rd_t rd_sel, rd_dec;
   logic unmapped;
   // grant register, parks on M0 out of reset
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= M0_GNT;
      else state <= state_next;
   // M0 wins ties; M1 keeps the bus until it drops its request
   always_comb begin
      state_next = state;
      if (state == M0_GNT) state_next = (!M0_req && M1_req) ? M1_GNT : M0_GNT;
      else state_next = M1_req ? M1_GNT : M0_GNT;
   end
   assign M0_grant = (state == M0_GNT);
   assign M1_grant = (state == M1_GNT);
   // granted master drives the shared command lines
   always_comb begin
      S_wr      = M1_grant ? M1_wr      : M0_wr;
      S_address = M1_grant ? M1_address : M0_address;
      S_din     = M1_grant ? M1_dout    : M0_dout;
   end
   // address map: 0x00-0x0F S0, 0x10-0x1F S1, 0x20-0x7F S2, upper half unmapped
   always_comb begin
      S0_sel   = (S_address[7:4] == 4'h0);
      S1_sel   = (S_address[7:4] == 4'h1);
      S2_sel   = !S_address[7] && (S_address[6:5] != 2'b00);
      unmapped = S_address[7];
      rd_dec   = S0_sel ? RD_S0 : S1_sel ? RD_S1 : S2_sel ? RD_S2 : RD_NONE;
   end
   // remember which slave answers next cycle; flag an unmapped access one cycle late
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd_sel  <= RD_NONE;
         bus_err <= 1'b0;
      end else begin
         rd_sel  <= S_wr ? RD_NONE : rd_dec;
         bus_err <= unmapped;
      end
   // return the remembered slave's data to both masters
   always_comb begin
      M_din = 32'h0;
      if (rd_sel == RD_S0) M_din = S0_dout;
      else if (rd_sel == RD_S1) M_din = S1_dout;
      else if (rd_sel == RD_S2) M_din = S2_dout;
   end
endmodule

// File: tb/tb_bus_arbiter_decoder.sv
// tb_bus_arbiter_decoder: directed stimulus with a cycle-level bus model and literal spot checks
module tb_bus_arbiter_decoder;
   logic clk = 1'b0;
   logic reset;
   logic M0_req, M1_req, M0_wr, M1_wr;
   logic [7:0] M0_address, M1_address;
   logic [31:0] M0_dout, M1_dout;
   logic M0_grant, M1_grant, S_wr;
   logic [7:0] S_address;
   logic [31:0] S_din;
   logic S0_sel, S1_sel, S2_sel;
   logic [31:0] S0_dout, S1_dout, S2_dout;
   logic [31:0] M_din;
   logic bus_err;
   int n_chk = 0;
   int n_fail = 0;
   int owner = 0;
   int last_reg = 3;
   bit last_um = 1'b0;
   always #5 clk = ~clk;
   bus_arbiter_decoder dut (
      .clk(clk), .reset(reset),
      .M0_req(M0_req), .M1_req(M1_req), .M0_wr(M0_wr), .M1_wr(M1_wr),
      .M0_address(M0_address), .M1_address(M1_address),
      .M0_dout(M0_dout), .M1_dout(M1_dout),
      .M0_grant(M0_grant), .M1_grant(M1_grant),
      .S_wr(S_wr), .S_address(S_address), .S_din(S_din),
      .S0_sel(S0_sel), .S1_sel(S1_sel), .S2_sel(S2_sel),
      .S0_dout(S0_dout), .S1_dout(S1_dout), .S2_dout(S2_dout),
      .M_din(M_din), .bus_err(bus_err)
   );
   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic int region(input logic [7:0] a);
      return (a < 8'h10) ? 0 : (a < 8'h20) ? 1 : (a < 8'h80) ? 2 : 3;
   endfunction
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   // model: who owns the bus, which slave answers next, whether last access was unmapped
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         owner    <= 0;
         last_reg <= 3;
         last_um  <= 1'b0;
      end else begin
         last_reg <= ((owner == 1) ? M1_wr : M0_wr) ? 3 : region((owner == 1) ? M1_address : M0_address);
         last_um  <= region((owner == 1) ? M1_address : M0_address) == 3;
         owner    <= (owner == 0) ? ((!M0_req && M1_req) ? 1 : 0) : (M1_req ? 1 : 0);
      end
   end
   // compare every cycle on the falling edge
   always @(negedge clk) begin
      logic [7:0] a;
      logic [31:0] ed;
      a  = (owner == 1) ? M1_address : M0_address;
      ed = (last_reg == 0) ? S0_dout : (last_reg == 1) ? S1_dout : (last_reg == 2) ? S2_dout : 32'h0;
      chk1("m0_grant", M0_grant, owner == 0);
      chk1("m1_grant", M1_grant, owner == 1);
      chk1("s_wr", S_wr, (owner == 1) ? M1_wr : M0_wr);
      chk32("s_address", {24'h0, S_address}, {24'h0, a});
      chk32("s_din", S_din, (owner == 1) ? M1_dout : M0_dout);
      chk1("s0_sel", S0_sel, region(a) == 0);
      chk1("s1_sel", S1_sel, region(a) == 1);
      chk1("s2_sel", S2_sel, region(a) == 2);
      chk32("m_din", M_din, ed);
      chk1("bus_err", bus_err, last_um);
   end
   localparam logic [31:0] S2V = 32'hC0DE0002;
   localparam logic [31:0] S0V = 32'h5A5A0000;
   int addrs [4] = '{8'h20, 8'h40, 8'h60, 8'h05};
   int vals [4] = '{11, 22, 33, 44};
   initial begin
      reset = 1'b1;
      M0_req = 0; M1_req = 0; M0_wr = 0; M1_wr = 0;
      M0_address = 0; M1_address = 0; M0_dout = 0; M1_dout = 0;
      S0_dout = S0V; S1_dout = 32'h1; S2_dout = S2V;
      tick; #1;
      chk1("rst_m0_grant", M0_grant, 1'b1);
      chk1("rst_m1_grant", M1_grant, 1'b0);
      chk32("rst_m_din", M_din, 32'h0);
      chk1("rst_bus_err", bus_err, 1'b0);
      tick; reset = 0; M0_wr = 1; M0_address = 8'h20; M0_dout = 32'd9999; #1;
      chk1("wr_s2_sel", S2_sel, 1'b1);
      chk32("wr_s_din", S_din, 32'd9999);
      chk1("wr_s_wr", S_wr, 1'b1);
      tick; M0_wr = 0; M0_address = 8'h16; #1;
      chk1("rd16_s1_sel", S1_sel, 1'b1);
      chk32("rd16_prev_wr_m_din", M_din, 32'h0);
      tick; M0_wr = 1; M0_address = 8'h00; M0_dout = 5; #1;
      chk32("rd16_m_din", M_din, 32'h1);
      tick; M0_wr = 0; M0_address = 8'h20; M1_req = 1; M1_wr = 0; M1_address = 8'h20; #1;
      chk32("after_wr_m_din", M_din, 32'h0);
      chk1("req_m0_still", M0_grant, 1'b1);
      tick; #1;
      chk1("m1_granted", M1_grant, 1'b1);
      chk1("m1_rd_s2_sel", S2_sel, 1'b1);
      chk32("handover_m_din", M_din, S2V);
      tick; M1_wr = 1; M1_address = 8'h11; M1_dout = 7; #1;
      chk1("m1_wr_s1_sel", S1_sel, 1'b1);
      chk1("m1_wr_s0_sel", S0_sel, 1'b0);
      chk32("m1_rd20_m_din", M_din, S2V);
      tick; M1_req = 0; M1_wr = 0; #1;
      chk1("m1_hold", M1_grant, 1'b1);
      chk32("m1_after_wr_m_din", M_din, 32'h0);
      tick; M0_req = 1; M1_req = 1; M0_address = 8'h05; #1;
      chk1("m0_back", M0_grant, 1'b1);
      chk32("m1_rd11_m_din", M_din, 32'h1);
      tick; M0_req = 0; #1;
      chk1("tie_m0", M0_grant, 1'b1);
      chk32("rd05_m_din", M_din, S0V);
      tick; M0_req = 1; #1;
      chk1("m0_drop_m1", M1_grant, 1'b1);
      tick; M1_req = 0; #1;
      chk1("no_preempt", M1_grant, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick;
         if (i < 4) M0_address = addrs[i][7:0];
         else begin M0_wr = 1; M0_address = 8'h7F; end
         if (i == 4) S0_dout = vals[3];
         else if (i > 0) S2_dout = vals[i-1];
         #1;
         if (i == 0) chk1("b2b_m0_grant", M0_grant, 1'b1);
         else chk32("b2b_m_din", M_din, vals[i-1]);
      end
      tick; M0_wr = 0; M0_address = 8'h90; #1;
      chk1("um_s0_sel", S0_sel, 1'b0);
      chk1("um_s1_sel", S1_sel, 1'b0);
      chk1("um_s2_sel", S2_sel, 1'b0);
      chk1("um_err_not_yet", bus_err, 1'b0);
      tick; M0_address = 8'h10; #1;
      chk1("um_bus_err", bus_err, 1'b1);
      chk32("um_m_din", M_din, 32'h0);
      tick; #1;
      chk1("um_err_clear", bus_err, 1'b0);
      chk32("rd10_m_din", M_din, 32'h1);
      tick; M1_req = 1; M0_req = 0; M1_address = 8'h21; #1;
      chk1("pre_m1_m0", M0_grant, 1'b1);
      tick; #1;
      chk1("pre_rst_m1", M1_grant, 1'b1);
      tick; #1;
      chk32("pre_rst_m_din", M_din, vals[2]);
      reset = 1; #1;
      chk1("mid_rst_m0", M0_grant, 1'b1);
      chk1("mid_rst_m1", M1_grant, 1'b0);
      chk32("mid_rst_m_din", M_din, 32'h0);
      tick; reset = 0; M1_req = 0; #1;
      chk1("post_rst_m0", M0_grant, 1'b1);
      tick; tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_decoder.md
# bus_arbiter_decoder

Shared-bus interconnect between the two bus masters (M0: host/testbench port, M1: DMAC) and the three slaves (S0: DMAC register file, S1: multiplier register file, S2: operand/result memory). Arbitrates the bus with a two-state grant FSM that parks on M0, muxes the granted master's command onto the slaves, decodes the address into one-hot slave selects, and returns read data through a registered read-select. Sits directly between the M0/M1 master ports and the slaves inside TOP.

## Interface
- S0_BASE, 8'h00: DMAC register window base (16 words).
- S1_BASE, 8'h10: multiplier register window base (16 words).
- S2_BASE, 8'h20: memory window base (96 words, 0x20–0x7F).
- clk  input  1  bus clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- M0_req, M1_req  input  1  bus request per master.
- M0_wr, M1_wr  input  1  1 = write, 0 = read.
- M0_address, M1_address  input  8  word address.
- M0_dout, M1_dout  input  32  write data.
- M0_grant, M1_grant  output  1  grant, exactly one high at all times.
- S_wr  output  1  granted master's wr.
- S_address  output  8  granted master's address.
- S_din  output  32  granted master's write data.
- S0_sel, S1_sel, S2_sel  output  1  one-hot slave select, all 0 if unmapped.
- S0_dout, S1_dout, S2_dout  input  32  slave read data (valid the cycle after address).
- M_din  output  32  read data to both masters.
- bus_err  output  1  one-cycle pulse: previous cycle addressed an unmapped location.

## Operation
- Arbiter FSM, states M0_GNT (reset state), M1_GNT.
  - M0_GNT: M0_req=0 and M1_req=1 -> M1_GNT; otherwise stay (M0 wins ties, M0 parks without requesting).
  - M1_GNT: M1_req=0 -> M0_GNT; otherwise stay (no preemption of M1 by M0).
- M0_grant = (state==M0_GNT), M1_grant = (state==M1_GNT); decoded from state register, no combinational path from req.
- Command mux: S_wr/S_address/S_din = granted master's wr/address/dout, combinational.
- Decoder on S_address: 0x00–0x0F -> S0_sel; 0x10–0x1F -> S1_sel; 0x20–0x7F -> S2_sel; 0x80–0xFF -> none. Selects are driven regardless of req (parked M0 accesses without req).
- Read path: rd_sel register (2 bits: S0/S1/S2/NONE) loads the decoded slave every cycle when S_wr=0, loads NONE when S_wr=1. M_din = slave dout selected by rd_sel; 32'h0 when NONE.
- bus_err register: set for one cycle when the prior cycle's S_address was unmapped (read or write); otherwise 0.

## Timing
- Reset (async, immediate): state=M0_GNT, M0_grant=1, M1_grant=0, rd_sel=NONE, M_din=0, bus_err=0. Command mux/selects follow M0 inputs combinationally during reset.
- Grant latency: req change sampled at edge k; grant switches after edge k, so the new master drives the bus from cycle k+1. Handover M0->M1->M0 costs one cycle each direction.
- Read latency: address presented in cycle n -> M_din valid in cycle n+1 (matches one-cycle slave read). Back-to-back reads to different slaves give one result per cycle.
- Grant change between address and data cycle: data still returned from rd_sel captured in address cycle; both masters see M_din.
- Write: single cycle, slave captures at the edge ending the cycle; M_din=0 the following cycle.
- Reset asserted mid-transfer: grant returns to M0 immediately, pending read data dropped (M_din=0).
- Simultaneous M0_req and M1_req in M0_GNT: stay M0_GNT.

## Test plan
- Reset then no requests: M0_grant=1, M1_grant=0, M_din=0, bus_err=0; M0 write 9999 to 0x20 -> S2_sel=1, S_din=9999, S_wr=1.
- M0 reads 0x16 with S1_dout=32'h1: S1_sel=1 in cycle n, M_din=32'h1 in cycle n+1, 0 afterwards if next is a write.
- M1_req=1, M0_req=0 at edge k: M1_grant=1 from cycle k+1; M1 reads 0x20 then writes 0x11 -> S2_sel then S0_sel/S1_sel per map (0x11 -> S1_sel); M1_req=0 -> M0_grant=1 next cycle.
- Both requests high in M0_GNT: M0 keeps grant; drop M0_req -> M1_grant next cycle; raise M0_req while M1 holding -> M1 keeps grant.
- Back-to-back reads 0x20, 0x40, 0x60, 0x05 with distinct slave data: M_din returns each value exactly one cycle later, no bubble.
- Access to 0x90: no select, bus_err=1 for exactly one cycle, M_din=0; assert reset mid-M1 transfer -> M0_grant=1 immediately.
